// File: rtl/xpb_accum_sched.sv
// ---------------------------------------------------------------------------
// xpb_accum_sched
//   Sequences the 5-bit overflow chunks of a reduction through an external
//   combinational xpb lookup table and accumulates the returned values.
//   One chunk is presented per RUN cycle. The finished sum is held in DONE
//   until the consumer accepts it.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start/start_ready request a reduction; ready only while IDLE
//   ovf_in            NUM_CHUNKS x 5-bit overflow vector, captured on accept
//   lut_en/sel/data   lookup request: table bank and address
//   lut_value         combinational table output for lut_sel/lut_data
//   sum_out/valid     accumulated sum, valid in DONE
//   sum_ready         consumer accepts sum_out
//   busy              high whenever not IDLE
//
// Configuration
//   XPB_SKIP_ZERO_EN  when defined, zero chunks are skipped using a pending
//                     mask; otherwise every chunk is visited in order.
// ---------------------------------------------------------------------------
module xpb_accum_sched #(
    parameter int DATA_W     = 1024,
    parameter int NUM_CHUNKS = 8,
    parameter int SEL_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        start_ready,
    input  logic [NUM_CHUNKS*5-1:0]     ovf_in,
    output logic                        lut_en,
    output logic [SEL_W-1:0]            lut_sel,
    output logic [4:0]                  lut_data,
    input  logic [DATA_W-1:0]           lut_value,
    output logic [DATA_W+SEL_W-1:0]     sum_out,
    output logic                        sum_valid,
    input  logic                        sum_ready,
    output logic                        busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [NUM_CHUNKS-1:0][4:0]      r_ovf;
    logic [DATA_W+SEL_W-1:0]         r_acc;
    logic [SEL_W-1:0]                w_idx;   // chunk presented this RUN cycle
    logic                            w_act;   // a real lookup happens this RUN cycle
    logic                            w_last;  // this RUN cycle is the final one
    logic                            w_accept;

    assign w_accept = (r_state == S_IDLE) && start;

`ifdef XPB_SKIP_ZERO_EN
    logic [NUM_CHUNKS-1:0] r_pend;
    logic [NUM_CHUNKS-1:0] w_pend_nxt;
    logic [NUM_CHUNKS-1:0] w_nz;

    always_comb begin
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            w_nz[i] = |ovf_in[5*i +: 5];
        end
    end

    // Lowest-indexed pending chunk wins; scanning downward leaves the lowest.
    always_comb begin
        w_idx = '0;
        for (int i = NUM_CHUNKS-1; i >= 0; i--) begin
            if (r_pend[i]) w_idx = SEL_W'(i);
        end
    end

    assign w_act      = |r_pend;
    assign w_pend_nxt = r_pend & ~(NUM_CHUNKS'(1) << w_idx);
    // An all-zero vector still spends one RUN cycle, with no lookup.
    assign w_last     = (w_pend_nxt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else if (w_accept) begin
            r_pend <= w_nz;
        end else if (r_state == S_RUN) begin
            r_pend <= w_pend_nxt;
        end
    end
`else
    logic [SEL_W-1:0] r_cnt;

    assign w_idx  = r_cnt;
    assign w_act  = 1'b1;
    assign w_last = (r_cnt == SEL_W'(NUM_CHUNKS-1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (r_state == S_RUN && !w_last) begin
            r_cnt <= r_cnt + SEL_W'(1);
        end
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; start in DONE (even during the handshake) is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start)     w_next = S_RUN;
            S_RUN:  if (w_last)    w_next = S_DONE;
            S_DONE: if (sum_ready) w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        start_ready = 1'b0;
        busy        = 1'b1;
        sum_valid   = 1'b0;
        lut_en      = 1'b0;
        lut_sel     = '0;
        lut_data    = '0;
        case (r_state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
            end
            S_RUN: begin
                if (w_act) begin
                    lut_en   = 1'b1;
                    lut_sel  = w_idx;
                    lut_data = r_ovf[w_idx];
                end
            end
            S_DONE:  sum_valid = 1'b1;
            default: ;
        endcase
    end

    assign sum_out = r_acc;

    // Capture and accumulate. lut_value is consumed in the same cycle it is
    // produced; the accumulator is wide enough for NUM_CHUNKS full-width terms.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_ovf <= ovf_in;
            r_acc <= '0;
        end else if (lut_en) begin
            r_acc <= r_acc + {{SEL_W{1'b0}}, lut_value};
        end
    end

endmodule
